ahb_lite_master: RTL

- Single-master AHB-Lite bus engine that drives the HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA inputs of the slave subsystem and consumes its HREADY/HRDATA/HRESP.
- Converts a simple command/stream interface into pipelined single or incrementing bursts of up to 16 beats.
- Used by the processor-side glue and by the system testbench as the only bus initiator.

---
 rtl/ahb_pkg.sv | 47 ++++
 rtl/ahb_lite_master_if.sv | 44 ++++
 rtl/ahb_addr_gen.sv | 37 +++
 rtl/ahb_lite_master.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, master FSM states and burst-type helper.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'b000,
    BurstIncr   = 3'b001,
    BurstIncr4  = 3'b011,
    BurstIncr8  = 3'b101,
    BurstIncr16 = 3'b111
  } hburst_e;

  typedef enum logic [2:0] {
    SizeByte = 3'd0,
    SizeHalf = 3'd1,
    SizeWord = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StLastData,
    StError
  } state_e;

  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // Fixed-length encodings only for 4/8/16 beats; any other length is open INCR.
  function automatic hburst_e burst_encode(input logic [4:0] len);
    hburst_e b;
    case (len)
      5'd1:    b = BurstSingle;
      5'd4:    b = BurstIncr4;
      5'd8:    b = BurstIncr8;
      5'd16:   b = BurstIncr16;
      default: b = BurstIncr;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ahb_lite_master_if.sv
// Command/stream side plus AHB-Lite bus signals of the single bus master.
interface ahb_lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [4:0]            cmd_len;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  rdata_last;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wdata, wdata_valid,
    input  HREADY, HRDATA, HRESP,
    output cmd_ready, wdata_ready, rdata, rdata_valid, rdata_last, done, err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len, wdata, wdata_valid,
    output HREADY, HRDATA, HRESP,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, rdata_last, done, err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/ahb_addr_gen.sv
// Beat address increment, 1KB boundary detect and command legality checks.
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [9:0]            i_cmd_addr_lo,
  input  logic [2:0]            i_cmd_size,
  input  logic [4:0]            i_cmd_len,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic                  o_boundary,
  output logic                  o_reject
);
  logic [11:0] w_bytes;
  logic [11:0] w_end;
  hburst_e     w_burst;
  logic        w_fixed;
  logic        w_misalign;

  assign o_next_addr = i_addr + (ADDR_WIDTH'(1) << i_size);
  assign o_boundary  = (i_addr[9:0] == 10'd0);

  // End offset within the 1KB page; equal to 1024 still fits exactly.
  assign w_bytes    = 12'(i_cmd_len) << i_cmd_size[1:0];
  assign w_end      = {2'b00, i_cmd_addr_lo} + w_bytes;
  assign w_burst    = burst_encode(i_cmd_len);
  assign w_fixed    = (w_burst == BurstIncr4) || (w_burst == BurstIncr8) ||
                      (w_burst == BurstIncr16);
  assign w_misalign = ((i_cmd_size == SizeHalf) && i_cmd_addr_lo[0]) ||
                      ((i_cmd_size == SizeWord) && (|i_cmd_addr_lo[1:0]));
  assign o_reject   = (i_cmd_len == 5'd0) || ({27'd0, i_cmd_len} > MAX_LEN) ||
                      (i_cmd_size > SizeWord) || w_misalign ||
                      (w_fixed && (w_end > 12'd1024));
endmodule

// File: rtl/ahb_lite_master.sv
// AHB-Lite master: turns commands into pipelined single/INCR bursts.
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic              clk,
  input  logic              rst,
  ahb_lite_master_if.master io_bus
);
  state_e                r_state, w_state_next;
  logic                  r_write;
  logic [2:0]            r_size;
  hburst_e               r_burst;
  logic [4:0]            r_len, r_beat;
  logic [ADDR_WIDTH-1:0] r_addr, w_next_addr;
  logic                  r_dp_valid, r_dp_write, r_dp_last;
  logic [DATA_WIDTH-1:0] r_hwdata;
  logic                  r_hold;
  htrans_e               r_htrans_held, w_htrans_new, w_htrans;
  logic                  r_done, r_err;
  logic w_cmd_ready, w_accept, w_reject, w_boundary, w_active, w_addr_ok;
  logic w_last_beat, w_dp_err, w_done_next, w_err_next, w_rvalid;

  ahb_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_LEN    (MAX_LEN)
  ) u_addr_gen (
    .i_addr        (r_addr),
    .i_size        (r_size),
    .i_cmd_addr_lo (io_bus.cmd_addr[9:0]),
    .i_cmd_size    (io_bus.cmd_size),
    .i_cmd_len     (io_bus.cmd_len),
    .o_next_addr   (w_next_addr),
    .o_boundary    (w_boundary),
    .o_reject      (w_reject)
  );

  assign w_cmd_ready = (r_state == StIdle) && !rst;
  assign w_accept    = io_bus.cmd_valid && w_cmd_ready;
  assign w_last_beat = (r_beat == r_len - 5'd1);
  assign w_dp_err    = r_dp_valid && io_bus.HRESP;
  assign w_active    = (w_htrans == TransNonseq) || (w_htrans == TransSeq);
  assign w_addr_ok   = (r_state == StAddr) && w_active && io_bus.HREADY && !w_dp_err;
  assign w_rvalid    = r_dp_valid && !r_dp_write && io_bus.HREADY && !io_bus.HRESP;

  assign w_done_next = (w_accept && w_reject) ||
                       (r_dp_valid && io_bus.HREADY && (io_bus.HRESP || r_dp_last)) ||
                       ((r_state == StError) && io_bus.HREADY);
  assign w_err_next  = (w_accept && w_reject) ||
                       (r_dp_valid && io_bus.HREADY && io_bus.HRESP) ||
                       ((r_state == StError) && io_bus.HREADY);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (w_accept && !w_reject) w_state_next = StAddr;
      StAddr: begin
        if (w_dp_err)                      w_state_next = io_bus.HREADY ? StIdle : StError;
        else if (w_addr_ok && w_last_beat) w_state_next = StLastData;
      end
      StLastData: begin
        if (w_dp_err)           w_state_next = io_bus.HREADY ? StIdle : StError;
        else if (io_bus.HREADY) w_state_next = StIdle;
      end
      StError:    if (io_bus.HREADY) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // Transfer type; a stalled address phase replays what was presented last cycle
  always_comb begin
    w_htrans_new = TransIdle;
    if (r_state == StAddr) begin
      if (!r_write || io_bus.wdata_valid) begin
        w_htrans_new = ((r_beat == 5'd0) || ((r_burst == BurstIncr) && w_boundary)) ?
                       TransNonseq : TransSeq;
      end else if (r_beat != 5'd0) begin
        w_htrans_new = TransBusy;
      end
    end
    w_htrans = ((r_state == StAddr) && r_hold) ? r_htrans_held : w_htrans_new;
  end

  // Command capture, beat/address advance, data-phase tracking and strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write       <= 1'b0;
      r_size        <= 3'd0;
      r_len         <= 5'd0;
      r_burst       <= BurstSingle;
      r_addr        <= '0;
      r_beat        <= 5'd0;
      r_dp_valid    <= 1'b0;
      r_dp_write    <= 1'b0;
      r_dp_last     <= 1'b0;
      r_hwdata      <= '0;
      r_hold        <= 1'b0;
      r_htrans_held <= TransIdle;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_accept && !w_reject) begin
        r_write <= io_bus.cmd_write;
        r_size  <= io_bus.cmd_size;
        r_len   <= io_bus.cmd_len;
        r_burst <= burst_encode(io_bus.cmd_len);
        r_addr  <= io_bus.cmd_addr;
        r_beat  <= 5'd0;
      end else if (w_addr_ok) begin
        r_addr <= w_next_addr;
        r_beat <= r_beat + 5'd1;
      end
      if (w_dp_err) begin
        r_dp_valid <= 1'b0;
      end else if (w_addr_ok) begin
        r_dp_valid <= 1'b1;
        r_dp_last  <= w_last_beat;
        r_dp_write <= r_write;
      end else if (io_bus.HREADY) begin
        r_dp_valid <= 1'b0;
      end
      if (w_addr_ok && r_write) r_hwdata <= io_bus.wdata;
      r_hold        <= (r_state == StAddr) && !io_bus.HREADY;
      r_htrans_held <= w_htrans;
      r_done        <= w_done_next;
      r_err         <= w_err_next;
    end
  end

  assign io_bus.cmd_ready   = w_cmd_ready;
  assign io_bus.wdata_ready = w_addr_ok && r_write;
  assign io_bus.rdata       = w_rvalid ? io_bus.HRDATA : '0;
  assign io_bus.rdata_valid = w_rvalid;
  assign io_bus.rdata_last  = w_rvalid && r_dp_last;
  assign io_bus.done        = r_done;
  assign io_bus.err         = r_err;
  assign io_bus.HADDR       = r_addr;
  assign io_bus.HTRANS      = w_htrans;
  assign io_bus.HWRITE      = r_write;
  assign io_bus.HSIZE       = r_size;
  assign io_bus.HBURST      = r_burst;
  assign io_bus.HPROT       = HPROT_DEFAULT;
  assign io_bus.HWDATA      = r_hwdata;
endmodule
